// File: rtl/conv_dual_acc.sv
`default_nettype none
// ============================================================================
// Module      : conv_dual_acc
// Description : Dual-filter 3x3 convolution accumulator. For each input
//               channel it fetches one weight word for filter A and one for
//               filter B from a synchronous ROM. It then consumes one 3x3
//               activation window and adds both signed dot products into two
//               full-precision accumulators. Results are presented with a
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_dual_acc #(
    parameter int ADDR_WIDTH = 11,
    parameter int ACC_WIDTH  = 44
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [6:0]            num_ch,
    output logic                  busy,
    input  logic                  act_valid,
    output logic                  act_ready,
    input  logic [143:0]          act_data,
    output logic [ADDR_WIDTH-1:0] wt_addr_a,
    output logic [ADDR_WIDTH-1:0] wt_addr_b,
    input  logic [143:0]          wt_q_a,
    input  logic [143:0]          wt_q_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_a,
    output logic [ACC_WIDTH-1:0]  out_b
);

    localparam int c_NUM_EL = 9;
    localparam int c_EL_W   = 16;
    localparam int c_PROD_W = 2 * c_EL_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_MAC   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 state_q,     state_d;
    logic [ADDR_WIDTH-1:0]  base_q,      base_d;
    logic [6:0]             nch_q,       nch_d;
    logic [6:0]             ch_q,        ch_d;
    logic [ACC_WIDTH-1:0]   acc_a_q,     acc_a_d;
    logic [ACC_WIDTH-1:0]   acc_b_q,     acc_b_d;
    logic [ADDR_WIDTH-1:0]  wt_addr_a_q, wt_addr_a_d;
    logic [ADDR_WIDTH-1:0]  wt_addr_b_q, wt_addr_b_d;
    logic                   busy_q,      busy_d;
    logic                   act_ready_q, act_ready_d;
    logic                   out_valid_q, out_valid_d;

    logic                   w_act_hs;
    logic                   w_more_ch;

    // Signed nine-element dot product; each 32-bit product is sign-extended
    // before accumulation so no intermediate can overflow.
    function automatic logic [ACC_WIDTH-1:0] f_dot(input logic [143:0] a,
                                                   input logic [143:0] w);
        logic [ACC_WIDTH-1:0]       sum;
        logic signed [c_PROD_W-1:0] prod;
        sum = '0;
        for (int k = 0; k < c_NUM_EL; k++) begin
            prod = $signed(a[c_EL_W*k +: c_EL_W]) * $signed(w[c_EL_W*k +: c_EL_W]);
            sum  = sum + {{(ACC_WIDTH-c_PROD_W){prod[c_PROD_W-1]}}, prod};
        end
        return sum;
    endfunction

    assign w_act_hs  = act_valid && act_ready_q;
    assign w_more_ch = ({1'b0, ch_q} + 8'd1) < {1'b0, nch_q};

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        nch_d       = nch_q;
        ch_d        = ch_q;
        acc_a_d     = acc_a_q;
        acc_b_d     = acc_b_q;
        wt_addr_a_d = wt_addr_a_q;
        wt_addr_b_d = wt_addr_b_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_a_d = '0;
                    acc_b_d = '0;
                    if (num_ch != 7'd0) begin
                        base_d  = base_addr;
                        nch_d   = num_ch;
                        ch_d    = 7'd0;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FETCH: begin
                // Filter B weights sit directly after the num_ch words of A.
                wt_addr_a_d = base_q + ADDR_WIDTH'(ch_q);
                wt_addr_b_d = base_q + ADDR_WIDTH'(nch_q) + ADDR_WIDTH'(ch_q);
                state_d     = ST_MAC;
            end
            ST_MAC: begin
                if (w_act_hs) begin
                    acc_a_d = acc_a_q + f_dot(act_data, wt_q_a);
                    acc_b_d = acc_b_q + f_dot(act_data, wt_q_b);
                    if (w_more_ch) begin
                        ch_d    = ch_q + 7'd1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // act_ready only from the second MAC cycle on, once ROM data has landed.
        busy_d      = (state_d != ST_IDLE);
        act_ready_d = (state_q == ST_MAC) && (state_d == ST_MAC);
        out_valid_d = (state_d == ST_DONE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            nch_q       <= '0;
            ch_q        <= '0;
            acc_a_q     <= '0;
            acc_b_q     <= '0;
            wt_addr_a_q <= '0;
            wt_addr_b_q <= '0;
            busy_q      <= 1'b0;
            act_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            nch_q       <= nch_d;
            ch_q        <= ch_d;
            acc_a_q     <= acc_a_d;
            acc_b_q     <= acc_b_d;
            wt_addr_a_q <= wt_addr_a_d;
            wt_addr_b_q <= wt_addr_b_d;
            busy_q      <= busy_d;
            act_ready_q <= act_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign busy      = busy_q;
    assign act_ready = act_ready_q;
    assign out_valid = out_valid_q;
    assign wt_addr_a = wt_addr_a_q;
    assign wt_addr_b = wt_addr_b_q;
    assign out_a     = acc_a_q;
    assign out_b     = acc_b_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_dual_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_dual_acc
// Description : Self-checking bench for conv_dual_acc with a synchronous ROM
//               model and an arithmetic dot-product reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_dual_acc;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [10:0]   base_addr;
    logic [6:0]    num_ch;
    logic          busy;
    logic          act_valid;
    logic          act_ready;
    logic [143:0]  act_data;
    logic [10:0]   wt_addr_a;
    logic [10:0]   wt_addr_b;
    logic [143:0]  wt_q_a;
    logic [143:0]  wt_q_b;
    logic          out_valid;
    logic          out_ready;
    logic [43:0]   out_a;
    logic [43:0]   out_b;

    logic [143:0]  rom [0:2047];
    logic [143:0]  act_mem [0:79];
    int            n_assert = 0;
    int            n_fail   = 0;

    conv_dual_acc #(.ADDR_WIDTH(11), .ACC_WIDTH(44)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_ch(num_ch), .busy(busy), .act_valid(act_valid),
        .act_ready(act_ready), .act_data(act_data), .wt_addr_a(wt_addr_a),
        .wt_addr_b(wt_addr_b), .wt_q_a(wt_q_a), .wt_q_b(wt_q_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
        .out_b(out_b)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data one clock after the address.
    always @(posedge clk) begin
        wt_q_a <= rom[wt_addr_a];
        wt_q_b <= rom[wt_addr_b];
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [143:0] rand144();
        logic [143:0] w;
        for (int k = 0; k < 9; k++) w[16*k +: 16] = 16'($urandom);
        return w;
    endfunction

    function automatic longint dot(input logic [143:0] a, input logic [143:0] w);
        longint s = 0;
        for (int k = 0; k < 9; k++)
            s += longint'($signed(a[16*k +: 16])) * longint'($signed(w[16*k +: 16]));
        return s;
    endfunction

    // mode 0 random, 1 all 16'h0001, 2 all zero, 3 all 16'h8000
    task automatic fill_act(input int mode, input int n);
        for (int c = 0; c < n; c++) begin
            case (mode)
                0: act_mem[c] = rand144();
                1: act_mem[c] = {9{16'h0001}};
                2: act_mem[c] = '0;
                default: act_mem[c] = {9{16'h8000}};
            endcase
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_act_ready"}, 64'(act_ready), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_a"}, 64'(out_a), 64'd0);
        check({tag, "_out_b"}, 64'(out_b), 64'd0);
        check({tag, "_wt_addr_a"}, 64'(wt_addr_a), 64'd0);
        check({tag, "_wt_addr_b"}, 64'(wt_addr_b), 64'd0);
    endtask

    // Runs one job; entered and left #1 after a rising edge.
    task automatic run_job(input logic [10:0] b, input int n, input int stall,
                           input int hold, input int abort_at);
        longint      sa = 0, sb = 0;
        logic [43:0] exp_a, exp_b;
        logic [10:0] addr_a0, addr_b0;
        int          idx = 0, stall_cnt = 0, cycles = 0;
        int          budget = (stall + 3) * n * 2 + 20;
        bit          hs;

        for (int c = 0; c < n; c++) begin
            sa += dot(act_mem[c], rom[11'(b + c)]);
            sb += dot(act_mem[c], rom[11'(b + n + c)]);
        end
        exp_a = sa[43:0];
        exp_b = sb[43:0];

        addr_a0   = wt_addr_a;
        addr_b0   = wt_addr_b;
        start     = 1'b1;
        base_addr = b;
        num_ch    = 7'(n);
        @(posedge clk); #1;
        start = 1'b0;

        while (!out_valid && cycles < budget) begin
            act_valid = (idx < n) && (stall_cnt >= stall);
            act_data  = (idx < n) ? act_mem[idx] : '0;
            if (act_ready) begin
                check("addr_a_mac", 64'(wt_addr_a), 64'(11'(b + idx)));
                check("addr_b_mac", 64'(wt_addr_b), 64'(11'(b + n + idx)));
                if (abort_at >= 0 && idx == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    check_all_zero("async_rst");
                    @(negedge clk);
                    rst_n     = 1'b1;
                    act_valid = 1'b0;
                    @(posedge clk); #1;
                    check("no_resume_busy", 64'(busy), 64'd0);
                    return;
                end
            end
            hs = act_valid && act_ready;
            @(posedge clk); #1;
            cycles++;
            if (hs) begin
                idx++;
                stall_cnt = 0;
            end else begin
                stall_cnt++;
            end
        end
        act_valid = 1'b0;

        check("out_valid_seen", 64'(out_valid), 64'd1);
        check("act_handshakes", 64'(idx), 64'(n));
        if (stall == 0) check("job_latency", 64'(cycles), 64'(3 * n));
        if (n == 0) begin
            check("addr_a_unchanged", 64'(wt_addr_a), 64'(addr_a0));
            check("addr_b_unchanged", 64'(wt_addr_b), 64'(addr_b0));
        end
        check("out_a", 64'(out_a), 64'(exp_a));
        check("out_b", 64'(out_b), 64'(exp_b));

        for (int i = 0; i < hold; i++) begin
            if (i == 2) begin
                start  = 1'b1;
                num_ch = 7'd3;
            end
            check("act_ready_done", 64'(act_ready), 64'd0);
            @(posedge clk); #1;
            start = 1'b0;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_out_a", 64'(out_a), 64'(exp_a));
            check("hold_out_b", 64'(out_b), 64'(exp_b));
        end

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_drop", 64'(out_valid), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("idle_busy2", 64'(busy), 64'd0);
        check("idle_valid2", 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [10:0] b;
        int          n;

        for (int i = 0; i < 2048; i++) rom[i] = rand144();
        for (int i = 100; i < 104; i++) rom[i] = {9{16'h8000}};

        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_ch = '0;
        act_valid = 1'b0; act_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("post_reset");

        // Single channel, unit activations: sums of ROM words 0 and 1.
        fill_act(1, 1);
        run_job(11'd0, 1, 0, 0, -1);

        // Zero activations with valid stalls.
        fill_act(2, 2);
        run_job(11'(1 + $urandom_range(0, 2000)), 2, 3, 0, -1);

        // Empty job goes straight to DONE.
        run_job(11'd500, 0, 0, 0, -1);

        // Back-pressure on the result with an ignored start.
        fill_act(0, 3);
        run_job(11'd42, 3, 0, 10, -1);

        // Most negative operands everywhere.
        fill_act(3, 2);
        run_job(11'd100, 2, 0, 0, -1);

        // Address wrap past the top of the ROM.
        fill_act(0, 10);
        run_job(11'd2040, 10, 1, 0, -1);

        // Reset in the middle of channel 3 of 5, then rerun the same job.
        fill_act(0, 5);
        b = 11'($urandom_range(0, 2047));
        run_job(b, 5, 0, 0, 3);
        run_job(b, 5, 0, 0, -1);

        // Random jobs.
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 38);
            fill_act(0, n);
            run_job(11'($urandom_range(0, 2047)), n, $urandom_range(0, 2),
                    $urandom_range(0, 3), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
